i2c_master_1: RTL and testbench

Single-byte I2C register initiator that issues write and read transactions to an I2C slave on the BLDC control bus. It drives open-drain SCL/SDA and runs two fixed frame types. Write is START, addr+W, index, data, STOP. Read is START, addr+W, index, repeated START, addr+R, data with master NACK, STOP. It sits between on-chip control logic (PID/setpoint sequencer) and the bidirectional pad cells at the top level.

---
 rtl/i2c_master_1_pkg.sv | 13 +
 rtl/i2c_master_1_bit_timer.sv | 28 ++
 rtl/i2c_master_1.sv | 156 +++++++++++++++
 tb/tb_i2c_master_1.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_master_1_pkg.sv
// i2c_master_1_pkg: shared states, constants and address-byte helper for the I2C register initiator
package i2c_master_1_pkg;
    typedef enum logic [2:0] {IDLE, START, BIT_TX, ACK_RX, RSTART, BIT_RX, MNACK, STOP} state_t;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ = 1'b1;
    localparam int QTR_DEF = 16;
    localparam logic [6:0] BLDC_ADDR = 7'h72;
    localparam logic [7:0] IDX_MIN = 8'h40;
    localparam logic [7:0] IDX_MAX = 8'h53;
    function automatic logic [7:0] addr_byte(input logic [6:0] a, input logic r);
        return {a, r};
    endfunction
endpackage

// File: rtl/i2c_master_1_bit_timer.sv
// i2c_bit_timer: quarter-bit phase counter; ports clk, rst_n, clr (restart at q0), wrap (last phase cycle), q (quarter 0..3)
module i2c_bit_timer #(
    parameter int QTR = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    output logic       wrap,
    output logic [1:0] q
);
    localparam logic [11:0] LAST = 12'(QTR - 1);
    logic [11:0] phase;
    assign wrap = phase == LAST;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
            q <= '0;
        end else if (clr) begin
            phase <= '0;
            q <= '0;
        end else if (wrap) begin
            phase <= '0;
            q <= q + 2'd1;
        end else begin
            phase <= phase + 12'd1;
        end
    end
endmodule

// File: rtl/i2c_master_1.sv
// i2c_master_1: single-byte I2C register write/read initiator driving open-drain SCL/SDA enables
// Ports: clk, rst_n (async active-low); start/rw/dev_addr/reg_index/wr_data request;
// rd_data, busy, done, ack_err status; scl_oe/sda_oe pull-low enables (pad output value tied 0); sda_in pad input.
module i2c_master_1
    import i2c_master_1_pkg::*;
#(
    parameter int QTR = QTR_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_index,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl_oe,
    input  logic       sda_in,
    output logic       sda_oe
);
    state_t state, state_n;
    logic [1:0] sync, q, bidx;
    logic [7:0] sh, ld_val, idx_l, data_l;
    logic [6:0] addr_l;
    logic [2:0] bcnt;
    logic rw_l, err, wrap, clr, q2_end, q_end, ld, fin;

    assign q2_end = wrap & (q == 2'd2);
    assign q_end = wrap & (q == 2'd3);
    // START is only three quarters long, so the timer is restarted when it ends
    assign clr = (state == IDLE) | (state == START & q2_end);
    assign busy = state != IDLE;

    i2c_bit_timer #(.QTR(QTR)) u_timer (
        .clk(clk),
        .rst_n(rst_n),
        .clr(clr),
        .wrap(wrap),
        .q(q)
    );

    always_comb begin
        state_n = state;
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        ld = 1'b0;
        ld_val = data_l;
        fin = 1'b0;
        case (state)
            IDLE: if (start) state_n = START;
            START: begin
                sda_oe = q != 2'd0;
                if (q2_end) state_n = BIT_TX;
            end
            BIT_TX: begin
                scl_oe = ~q[1];
                sda_oe = ~sh[7];
                if (q_end && bcnt == 3'd7) state_n = ACK_RX;
            end
            ACK_RX: begin
                scl_oe = ~q[1];
                if (q_end) begin
                    if (err) state_n = STOP;
                    else if (bidx == 2'd0) begin
                        state_n = BIT_TX;
                        ld = 1'b1;
                        ld_val = idx_l;
                    end else if (bidx == 2'd1) begin
                        state_n = rw_l ? RSTART : BIT_TX;
                        ld = ~rw_l;
                    end else state_n = rw_l ? BIT_RX : STOP;
                end
            end
            RSTART: begin
                scl_oe = q == 2'd0;
                sda_oe = q[1];
                if (q_end) begin
                    state_n = BIT_TX;
                    ld = 1'b1;
                    ld_val = addr_byte(addr_l, RW_READ);
                end
            end
            BIT_RX: begin
                scl_oe = ~q[1];
                if (q_end && bcnt == 3'd7) state_n = MNACK;
            end
            MNACK: begin
                scl_oe = ~q[1];
                if (q_end) state_n = STOP;
            end
            STOP: begin
                scl_oe = ~q[1];
                sda_oe = q != 2'd3;
                if (q_end) begin
                    state_n = IDLE;
                    fin = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // sh is the transmit shifter in BIT_TX and the receive shifter in BIT_RX;
    // bcnt wraps 7->0 on its own, so it is already zero when the next byte starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sync <= 2'b11;
            sh <= '0;
            bcnt <= '0;
            bidx <= '0;
            err <= 1'b0;
            rw_l <= 1'b0;
            addr_l <= '0;
            idx_l <= '0;
            data_l <= '0;
            rd_data <= '0;
            ack_err <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_n;
            sync <= {sync[0], sda_in};
            done <= fin;
            if (state == IDLE && start) begin
                rw_l <= rw;
                addr_l <= dev_addr;
                idx_l <= reg_index;
                data_l <= wr_data;
                sh <= addr_byte(dev_addr, RW_WRITE);
                bcnt <= '0;
                bidx <= '0;
                err <= 1'b0;
                ack_err <= 1'b0;
            end
            if (ld) begin
                sh <= ld_val;
                bcnt <= '0;
            end
            if (state == BIT_TX && q_end) begin
                sh <= {sh[6:0], 1'b0};
                bcnt <= bcnt + 3'd1;
            end
            if (state == BIT_RX && q2_end) sh <= {sh[6:0], sync[1]};
            if (state == BIT_RX && q_end) bcnt <= bcnt + 3'd1;
            if (state == ACK_RX && q2_end) err <= err | sync[1];
            if (state == ACK_RX && q_end) bidx <= bidx + 2'd1;
            if (fin) begin
                ack_err <= err;
                if (rw_l && !err) rd_data <= sh;
            end
        end
    end
endmodule

// File: tb/tb_i2c_master_1.sv
// tb_i2c_master_1: directed bench with open-drain bus, behavioural slave and bus event monitor
module tb_i2c_master_1;
    import i2c_master_1_pkg::*;
    localparam int Q = 16;
    localparam int S_EV = 1000;
    localparam int P_EV = 2000;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, rw = 1'b0;
    logic [6:0] dev_addr = '0;
    logic [7:0] reg_index = '0, wr_data = '0, rd_data;
    logic busy, done, ack_err, scl_oe, sda_oe, sda_in;
    logic slv_pull = 1'b0;
    logic scl_line, sda_line;
    int vectors = 0, miscompares = 0;
    int ev[$];
    int busy_total = 0, done_total = 0, b_base = 0, d_base = 0, e_base = 0;

    assign scl_line = ~scl_oe;
    assign sda_line = ~(sda_oe | slv_pull);
    assign sda_in = sda_line;

    i2c_master_1 #(.QTR(Q)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .dev_addr(dev_addr),
        .reg_index(reg_index), .wr_data(wr_data), .rd_data(rd_data), .busy(busy),
        .done(done), .ack_err(ack_err), .scl_oe(scl_oe), .sda_in(sda_in), .sda_oe(sda_oe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (busy) busy_total++;
        if (done) done_total++;
    end

    // Slave at BLDC_ADDR acks indices IDX_MIN..IDX_MAX and returns 8'h3C on reads
    logic p_scl = 1'b1, p_sda = 1'b1, c_scl, c_sda, s_tx = 1'b0, s_rdp = 1'b0, s_ack;
    logic [8:0] m_sh = '0;
    logic [7:0] s_rx = '0, s_txd = 8'h3C;
    int m_cnt = 0, s_cnt = 0, s_byte = 0;
    always @(negedge clk) begin
        c_scl = scl_line;
        c_sda = sda_line;
        if (!rst_n) begin
            slv_pull = 1'b0; s_tx = 1'b0; s_rdp = 1'b0; m_cnt = 0; s_cnt = 0; s_byte = 0;
            c_scl = 1'b1; c_sda = 1'b1;
        end else if (p_scl && c_scl && p_sda && !c_sda) begin
            ev.push_back(S_EV); m_cnt = 0; s_cnt = 0; s_byte = 0; s_tx = 1'b0; slv_pull = 1'b0;
        end else if (p_scl && c_scl && !p_sda && c_sda) begin
            ev.push_back(P_EV); m_cnt = 0; s_cnt = 0; s_tx = 1'b0; slv_pull = 1'b0;
        end else if (!p_scl && c_scl) begin
            m_sh = {m_sh[7:0], c_sda};
            m_cnt++;
            if (m_cnt == 9) begin ev.push_back(int'(m_sh)); m_cnt = 0; end
            if (s_cnt < 8) s_rx = {s_rx[6:0], c_sda};
            s_cnt++;
        end else if (p_scl && !c_scl) begin
            if (s_cnt == 8) begin
                if (s_tx) slv_pull = 1'b0;
                else begin
                    s_ack = (s_byte == 0) ? (s_rx[7:1] == BLDC_ADDR) :
                            (s_byte == 1) ? (s_rx >= IDX_MIN && s_rx <= IDX_MAX) : 1'b1;
                    slv_pull = s_ack;
                    s_rdp = (s_byte == 0) && s_ack && s_rx[0];
                end
            end else if (s_cnt == 9) begin
                s_cnt = 0; s_byte++; slv_pull = 1'b0;
                if (s_rdp) begin s_tx = 1'b1; s_rdp = 1'b0; slv_pull = ~s_txd[7]; end
            end else if (s_tx && s_cnt >= 1 && s_cnt <= 7) slv_pull = ~s_txd[7 - s_cnt];
        end
        p_scl = c_scl;
        p_sda = c_sda;
    end

    function automatic int ev_at(int k);
        return (e_base + k < ev.size()) ? ev[e_base + k] : -1;
    endfunction

    task automatic kick(input logic r, input logic [6:0] a, input logic [7:0] i, input logic [7:0] d);
        e_base = ev.size(); b_base = busy_total; d_base = done_total;
        rw = r; dev_addr = a; reg_index = i; wr_data = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0; rw = ~r; dev_addr = ~a; reg_index = ~i; wr_data = ~d;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 6000; k++) begin
            if (done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        vectors++; if ({scl_oe, sda_oe, busy, done, ack_err} !== 5'b0) begin miscompares++; $display("FAIL reset_ctl: got %b expected 00000", {scl_oe, sda_oe, busy, done, ack_err}); end
        vectors++; if (rd_data !== 8'h00) begin miscompares++; $display("FAIL reset_rd: got %h expected 00", rd_data); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if ({scl_oe, sda_oe, busy} !== 3'b0) begin miscompares++; $display("FAIL idle_ctl: got %b expected 000", {scl_oe, sda_oe, busy}); end
    endtask

    task automatic test_write;
        bit ok;
        int exp[$] = '{S_EV, 'h1C8, 'h08A, 'h14A, P_EV};
        kick(RW_WRITE, 7'h72, 8'h45, 8'hA5);
        wait_done(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL wr_done: got timeout expected done"); end
        vectors++; if (busy_total - b_base !== 1840) begin miscompares++; $display("FAIL wr_cycles: got %0d expected 1840", busy_total - b_base); end
        vectors++; if ({busy, ack_err} !== 2'b00) begin miscompares++; $display("FAIL wr_status: got %b expected 00", {busy, ack_err}); end
        vectors++; if (ev.size() - e_base !== exp.size()) begin miscompares++; $display("FAIL wr_evcount: got %0d expected %0d", ev.size() - e_base, exp.size()); end
        foreach (exp[k]) begin vectors++; if (ev_at(k) !== exp[k]) begin miscompares++; $display("FAIL wr_ev%0d: got %0h expected %0h", k, ev_at(k), exp[k]); end end
    endtask

    task automatic test_read;
        bit ok;
        int exp[$] = '{S_EV, 'h1C8, 'h082, S_EV, 'h1CA, 'h079, P_EV};
        repeat (3) @(negedge clk);
        kick(RW_READ, 7'h72, 8'h41, 8'h00);
        wait_done(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rd_done: got timeout expected done"); end
        vectors++; if (busy_total - b_base !== 2480) begin miscompares++; $display("FAIL rd_cycles: got %0d expected 2480", busy_total - b_base); end
        vectors++; if (rd_data !== 8'h3C) begin miscompares++; $display("FAIL rd_data: got %h expected 3c", rd_data); end
        vectors++; if (ack_err !== 1'b0) begin miscompares++; $display("FAIL rd_ackerr: got %b expected 0", ack_err); end
        vectors++; if (ev.size() - e_base !== exp.size()) begin miscompares++; $display("FAIL rd_evcount: got %0d expected %0d", ev.size() - e_base, exp.size()); end
        foreach (exp[k]) begin vectors++; if (ev_at(k) !== exp[k]) begin miscompares++; $display("FAIL rd_ev%0d: got %0h expected %0h", k, ev_at(k), exp[k]); end end
    endtask

    task automatic test_addr_nack;
        bit ok;
        int exp[$] = '{S_EV, 'h041, P_EV};
        repeat (3) @(negedge clk);
        kick(RW_READ, 7'h10, 8'h45, 8'h00);
        wait_done(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL an_done: got timeout expected done"); end
        vectors++; if (busy_total - b_base !== 43 * Q) begin miscompares++; $display("FAIL an_cycles: got %0d expected %0d", busy_total - b_base, 43 * Q); end
        vectors++; if (ack_err !== 1'b1) begin miscompares++; $display("FAIL an_ackerr: got %b expected 1", ack_err); end
        vectors++; if (rd_data !== 8'h3C) begin miscompares++; $display("FAIL an_rdhold: got %h expected 3c", rd_data); end
        foreach (exp[k]) begin vectors++; if (ev_at(k) !== exp[k]) begin miscompares++; $display("FAIL an_ev%0d: got %0h expected %0h", k, ev_at(k), exp[k]); end end
        repeat (5) @(negedge clk);
        vectors++; if (ack_err !== 1'b1) begin miscompares++; $display("FAIL an_ackhold: got %b expected 1", ack_err); end
    endtask

    task automatic test_index_nack;
        bit ok;
        int exp[$] = '{S_EV, 'h1C8, 'h0C1, P_EV};
        repeat (3) @(negedge clk);
        kick(RW_WRITE, 7'h72, 8'h60, 8'hA5);
        vectors++; if (ack_err !== 1'b0) begin miscompares++; $display("FAIL in_ackclr: got %b expected 0", ack_err); end
        wait_done(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL in_done: got timeout expected done"); end
        vectors++; if (busy_total - b_base !== 79 * Q) begin miscompares++; $display("FAIL in_cycles: got %0d expected %0d", busy_total - b_base, 79 * Q); end
        vectors++; if (ack_err !== 1'b1) begin miscompares++; $display("FAIL in_ackerr: got %b expected 1", ack_err); end
        vectors++; if (ev.size() - e_base !== exp.size()) begin miscompares++; $display("FAIL in_evcount: got %0d expected %0d", ev.size() - e_base, exp.size()); end
        foreach (exp[k]) begin vectors++; if (ev_at(k) !== exp[k]) begin miscompares++; $display("FAIL in_ev%0d: got %0h expected %0h", k, ev_at(k), exp[k]); end end
    endtask

    task automatic test_start_ignored;
        bit ok;
        int exp[$] = '{S_EV, 'h1C8, 'h08A, 'h14A, P_EV};
        repeat (3) @(negedge clk);
        kick(RW_WRITE, 7'h72, 8'h45, 8'hA5);
        repeat (300) @(negedge clk);
        rw = RW_READ; wr_data = 8'h5A; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL si_done: got timeout expected done"); end
        vectors++; if (busy_total - b_base !== 1840) begin miscompares++; $display("FAIL si_cycles: got %0d expected 1840", busy_total - b_base); end
        foreach (exp[k]) begin vectors++; if (ev_at(k) !== exp[k]) begin miscompares++; $display("FAIL si_ev%0d: got %0h expected %0h", k, ev_at(k), exp[k]); end end
        repeat (40) @(negedge clk);
        vectors++; if (done_total - d_base !== 1) begin miscompares++; $display("FAIL si_donecnt: got %0d expected 1", done_total - d_base); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        repeat (3) @(negedge clk);
        kick(RW_WRITE, 7'h72, 8'h50, 8'h11);
        wait_done(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL bb_done1: got timeout expected done"); end
        kick(RW_READ, 7'h72, 8'h50, 8'h00);
        vectors++; if ({busy, scl_oe, sda_oe} !== 3'b100) begin miscompares++; $display("FAIL bb_accept: got %b expected 100", {busy, scl_oe, sda_oe}); end
        repeat (Q - 1) @(negedge clk);
        vectors++; if (sda_oe !== 1'b0) begin miscompares++; $display("FAIL bb_q0end: got %b expected 0", sda_oe); end
        @(negedge clk);
        vectors++; if ({scl_oe, sda_oe} !== 2'b01) begin miscompares++; $display("FAIL bb_sdafall: got %b expected 01", {scl_oe, sda_oe}); end
        wait_done(ok);
        vectors++; if (busy_total - b_base !== 2480) begin miscompares++; $display("FAIL bb_cycles: got %0d expected 2480", busy_total - b_base); end
        vectors++; if (rd_data !== 8'h3C) begin miscompares++; $display("FAIL bb_rd: got %h expected 3c", rd_data); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int exp[$] = '{S_EV, 'h1C8, 'h0A6, 'h186, P_EV};
        repeat (3) @(negedge clk);
        kick(RW_READ, 7'h72, 8'h42, 8'h00);
        repeat (137 * Q) @(negedge clk);
        vectors++; if ({busy, scl_oe} !== 2'b10) begin miscompares++; $display("FAIL rm_pre: got %b expected 10", {busy, scl_oe}); end
        rst_n = 1'b0;
        #1;
        vectors++; if ({scl_oe, sda_oe, busy} !== 3'b000) begin miscompares++; $display("FAIL rm_lines: got %b expected 000", {scl_oe, sda_oe, busy}); end
        vectors++; if (rd_data !== 8'h00) begin miscompares++; $display("FAIL rm_rdclr: got %h expected 00", rd_data); end
        repeat (20) @(negedge clk);
        vectors++; if (done_total - d_base !== 0) begin miscompares++; $display("FAIL rm_nodone: got %0d expected 0", done_total - d_base); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        kick(RW_WRITE, 7'h72, 8'h53, 8'hC3);
        wait_done(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rm_done: got timeout expected done"); end
        vectors++; if (busy_total - b_base !== 1840) begin miscompares++; $display("FAIL rm_cycles: got %0d expected 1840", busy_total - b_base); end
        vectors++; if ({ack_err, rd_data} !== 9'h000) begin miscompares++; $display("FAIL rm_status: got %h expected 000", {ack_err, rd_data}); end
        foreach (exp[k]) begin vectors++; if (ev_at(k) !== exp[k]) begin miscompares++; $display("FAIL rm_ev%0d: got %0h expected %0h", k, ev_at(k), exp[k]); end end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_addr_nack;
        test_index_nack;
        test_start_ignored;
        test_back_to_back;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
